// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM state and read/write encodings for the SRAM arbiter
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/sram_arbiter_arb_rr2.sv
// arb_rr2: combinational 2-way picker with a registered round-robin pointer
module arb_rr2
    import sram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);

    logic ptr_q, ptr_d;

    // pointer moves to the port that did not win when a transaction retires
    always_comb ptr_d = adv_i ? ~last_i : ptr_q;

    // pointer register, favours port 0 out of reset
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

    // lone requester wins; on contention the pointer (or port 0 in fixed mode) decides
    always_comb begin
        win_o   = (req_i == 2'b10) ? 1'b1 :
                  (req_i == 2'b11) ? ((FIXED_PRIO != 0) ? 1'b0 : ptr_q) : 1'b0;
        valid_o = |req_i;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one EXT_SRAM request port between two masters with a watchdog
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_dtw,
    output logic [DATA_W-1:0] p0_dtr,
    output logic              p0_done,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_dtw,
    output logic [DATA_W-1:0] p1_dtr,
    output logic              p1_done,
    output logic              p1_err,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dtw,
    input  logic [DATA_W-1:0] mem_dtr,
    input  logic              mem_done,
    output logic              busy,
    output logic              grant
);

    state_t            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dtw_q, mem_dtw_d;
    logic [DATA_W-1:0] dtr0_q, dtr0_d, dtr1_q, dtr1_d, cap;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              busy_q, busy_d, grant_q, grant_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              win, win_v, adv, expired;

    arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({p1_req, p0_req}),
        .adv_i   (adv),
        .last_i  (grant_q),
        .win_o   (win),
        .valid_o (win_v)
    );

    assign expired = (wd_q == TO_W'(TIMEOUT - 1));

    // next-state and registered-output logic; everything holds unless the state says otherwise
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_dtw_d   = mem_dtw_q;
        grant_d     = grant_q;
        wd_d        = wd_q;
        dtr0_d      = dtr0_q;
        dtr1_d      = dtr1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        adv         = 1'b0;
        cap         = mem_done ? mem_dtr : '0;
        case (state_q)
            ST_IDLE: if (win_v) begin
                state_d     = ST_BUSY;
                grant_d     = win;
                mem_valid_d = 1'b1;
                mem_rw_d    = win ? p1_rw : p0_rw;
                mem_addr_d  = win ? p1_addr : p0_addr;
                mem_dtw_d   = win ? p1_dtw : p0_dtw;
                wd_d        = '0;
            end
            ST_BUSY: if (mem_done || expired) begin
                state_d     = ST_RESP;
                mem_valid_d = 1'b0;
                dtr0_d      = grant_q ? dtr0_q : cap;
                dtr1_d      = grant_q ? cap : dtr1_q;
                done0_d     = ~grant_q;
                done1_d     = grant_q;
                err0_d      = ~grant_q & ~mem_done;
                err1_d      = grant_q & ~mem_done;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                adv     = (FIXED_PRIO == 0);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= RW_READ;
            mem_addr_q  <= '0;
            mem_dtw_q   <= '0;
            grant_q     <= 1'b0;
            wd_q        <= '0;
            dtr0_q      <= '0;
            dtr1_q      <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_dtw_q   <= mem_dtw_d;
            grant_q     <= grant_d;
            wd_q        <= wd_d;
            dtr0_q      <= dtr0_d;
            dtr1_q      <= dtr1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_dtw   = mem_dtw_q;
    assign p0_dtr    = dtr0_q;
    assign p1_dtr    = dtr1_q;
    assign p0_done   = done0_q;
    assign p1_done   = done1_q;
    assign p0_err    = err0_q;
    assign p1_err    = err1_q;
    assign busy      = busy_q;
    assign grant     = grant_q;

endmodule
